// File: rtl/tape_encoder.sv
// Unary-addition tape encoder: streams BLANK* A^a ADD A^b BLANK* symbols
// over a valid/ready handshake, one symbol per transfer.
module tape_encoder #(
    parameter int LEAD  = 6,
    parameter int TRAIL = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    output logic       busy,
    output logic [1:0] sym_out,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [5:0] sym_count,
    output logic       done
);

    localparam logic [1:0] SYM_A     = 2'b00;
    localparam logic [1:0] SYM_ADD   = 2'b01;
    localparam logic [1:0] SYM_BLANK = 2'b10;

    typedef enum logic [2:0] {
        IDLE, LEADB, OPA, ADD, OPB, TRAILB, FIN
    } state_t;

    state_t     state;
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [3:0] cnt;
    logic       xfer;
    logic       last;

    assign xfer = sym_valid & sym_ready;
    assign last = (cnt == 4'd0);

    // cnt holds symbols remaining in the current state minus one
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            sym_valid <= 1'b0;
            sym_out   <= SYM_BLANK;
            sym_count <= '0;
            done      <= 1'b0;
        end else begin
            if (xfer) begin
                sym_count <= sym_count + 6'd1;
                cnt       <= cnt - 4'd1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_r       <= a_in;
                        b_r       <= b_in;
                        sym_count <= '0;
                        cnt       <= 4'(LEAD - 1);
                        busy      <= 1'b1;
                        sym_valid <= 1'b1;
                        sym_out   <= SYM_BLANK;
                        state     <= LEADB;
                    end
                end
                LEADB: begin
                    if (xfer && last) begin
                        if (a_r != 4'd0) begin
                            cnt     <= a_r - 4'd1;
                            sym_out <= SYM_A;
                            state   <= OPA;
                        end else begin
                            sym_out <= SYM_ADD;
                            state   <= ADD;
                        end
                    end
                end
                OPA: begin
                    if (xfer && last) begin
                        sym_out <= SYM_ADD;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    if (xfer) begin
                        if (b_r != 4'd0) begin
                            cnt     <= b_r - 4'd1;
                            sym_out <= SYM_A;
                            state   <= OPB;
                        end else begin
                            cnt     <= 4'(TRAIL - 1);
                            sym_out <= SYM_BLANK;
                            state   <= TRAILB;
                        end
                    end
                end
                OPB: begin
                    if (xfer && last) begin
                        cnt     <= 4'(TRAIL - 1);
                        sym_out <= SYM_BLANK;
                        state   <= TRAILB;
                    end
                end
                TRAILB: begin
                    if (xfer && last) begin
                        sym_valid <= 1'b0;
                        sym_out   <= SYM_BLANK;
                        done      <= 1'b1;
                        state     <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    sym_valid <= 1'b0;
                    sym_out   <= SYM_BLANK;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tape_encoder.sv
// Bench for tape_encoder: table vectors, corner sequences and random
// tapes checked against a symbol-queue model of the tape.
module tb_tape_encoder;

    localparam int LEAD  = 6;
    localparam int TRAIL = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       busy;
    logic [1:0] sym_out;
    logic       sym_valid;
    logic       sym_ready;
    logic [5:0] sym_count;
    logic       done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tape_encoder #(.LEAD(LEAD), .TRAIL(TRAIL)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_count (sym_count),
        .done      (done)
    );

    typedef struct {
        int a;
        int b;
        int mode;
        int len;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic idle_chk(input int cnt);
        chk("idle_busy", int'(busy), 0);
        chk("idle_valid", int'(sym_valid), 0);
        chk("idle_sym", int'(sym_out), 2);
        chk("idle_done", int'(done), 0);
        chk("idle_count", int'(sym_count), cnt);
    endtask

    // Called at a negedge with the DUT idle. mode: 0 ready high,
    // 1 ready toggling, 2 ready random. restart_at: cycle to re-pulse
    // start with a_in=9. rst_after: transfers before a reset (0 = none).
    task automatic run_tape(input int a, input int b, input int mode,
                            input int len, input int restart_at,
                            input int rst_after);
        logic [1:0] q[$];
        logic [1:0] prev;
        int idx;
        int cyc;
        bit seen_done;
        bit stalled;
        bit rdy;
        q = {};
        for (int i = 0; i < LEAD; i++) q.push_back(2'b10);
        for (int i = 0; i < a; i++) q.push_back(2'b00);
        q.push_back(2'b01);
        for (int i = 0; i < b; i++) q.push_back(2'b00);
        for (int i = 0; i < TRAIL; i++) q.push_back(2'b10);
        a_in = 4'(a);
        b_in = 4'(b);
        start = 1'b1;
        sym_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        a_in = 4'($urandom);
        b_in = 4'($urandom);
        idx = 0;
        cyc = 1;
        seen_done = 1'b0;
        stalled = 1'b0;
        prev = 2'b10;
        while (!seen_done && cyc < 400) begin
            if (cyc == restart_at) begin
                start = 1'b1;
                a_in = 4'd9;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen_done = 1'b1;
                chk("done_xfers", idx, q.size());
                chk("done_count", int'(sym_count), len);
                chk("done_valid", int'(sym_valid), 0);
                chk("done_sym", int'(sym_out), 2);
                chk("done_busy", int'(busy), 1);
                if (mode == 0) chk("latency", cyc, len + 1);
            end else if (rst_after > 0 && idx == rst_after) begin
                rst = 1'b1;
                start = 1'b1;
                sym_ready = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                sym_ready = 1'b0;
                idle_chk(0);
                return;
            end else begin
                chk("run_valid", int'(sym_valid), 1);
                chk("run_busy", int'(busy), 1);
                chk("run_count", int'(sym_count), idx);
                if (stalled) chk("stall_hold", int'(sym_out), int'(prev));
                if (idx < q.size())
                    chk("sym", int'(sym_out), int'(q[idx]));
                else
                    chk("overrun", idx, q.size() - 1);
                case (mode)
                    0: rdy = 1'b1;
                    1: rdy = cyc[0];
                    default: rdy = 1'($urandom);
                endcase
                sym_ready = rdy;
                if (rdy) idx++;
                stalled = !rdy;
                prev = sym_out;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!seen_done) begin
            chk("timeout_done", 0, 1);
            return;
        end
        sym_ready = 1'($urandom);
        @(negedge clk);
        idle_chk(len);
    endtask

    initial begin
        tbl[0] = '{a: 3, b: 4, mode: 0, len: 19};
        tbl[1] = '{a: 0, b: 0, mode: 0, len: 12};
        tbl[2] = '{a: 15, b: 15, mode: 1, len: 42};
        tbl[3] = '{a: 15, b: 0, mode: 2, len: 27};
        tbl[4] = '{a: 0, b: 15, mode: 2, len: 27};
        tbl[5] = '{a: 1, b: 1, mode: 0, len: 14};

        rst = 1'b1;
        start = 1'b1;
        sym_ready = 1'b1;
        a_in = 4'd5;
        b_in = 4'd5;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        idle_chk(0);

        for (int i = 0; i < 6; i++)
            run_tape(tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].len, 0, 0);

        run_tape(2, 1, 0, 15, 3, 0);
        run_tape(3, 4, 0, 19, 0, 8);
        run_tape(1, 1, 0, 14, 0, 0);

        for (int n = 0; n < 20; n++) begin
            int ra;
            int rb;
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            run_tape(ra, rb, 2, LEAD + ra + 1 + rb + TRAIL, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
